// File: rtl/nn_seq_if.sv
// Host/datapath bus of the neural-net sequencer: run handshake plus BRAM address,
// enable and register-write strobes.
interface nn_seq_if #(
  parameter int A  = 10,
  parameter int ND = 8,
  parameter int K  = 40
);
  logic          start;
  logic          abort;
  logic          mode;
  logic [15:0]   batch;
  logic [15:0]   max_it;
  logic [A-1:0]  x_addr;
  logic [A-1:0]  y_addr;
  logic [A-1:0]  t_addr;
  logic [A-1:0]  nd_addr;
  logic          e_x;
  logic          e_nd;
  logic          in_we;
  logic [ND-1:0] c_we;
  logic [K-1:0]  bp_we;
  logic          dtb;
  logic          nd_we;
  logic          y_we;
  logic          busy;
  logic          done;
  logic [15:0]   iter;

  modport master (
    input  start, abort, mode, batch, max_it,
    output x_addr, y_addr, t_addr, nd_addr, e_x, e_nd, in_we, c_we, bp_we,
           dtb, nd_we, y_we, busy, done, iter
  );

  modport slave (
    output start, abort, mode, batch, max_it,
    input  x_addr, y_addr, t_addr, nd_addr, e_x, e_nd, in_we, c_we, bp_we,
           dtb, nd_we, y_we, busy, done, iter
  );
endinterface

// File: rtl/nn_seq_ctrl.sv
// Load / run / save sequencer for the fixed-point neural-net layer array.
// Define NN_SEQ_BATCH_ADVANCE_EN to keep x/t addresses running across iterations.
module nn_seq_ctrl #(
  parameter int              LTOT  = 3,
  parameter logic [32*LTOT-1:0] LR = {32'd4, 32'd4, 32'd4},
  parameter int              A     = 10,
  parameter int              ND    = 8,
  parameter int              WT    = 32,
  parameter int              T0    = 10,
  parameter int              NDATA = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  nn_seq_if.master bus
);

`ifdef NN_SEQ_BATCH_ADVANCE_EN
  localparam bit ADV = 1'b1;
`else
  localparam bit ADV = 1'b0;
`endif

  localparam int K  = WT + ND;
  localparam int SX = int'(LR[31:0]);
  localparam int CW = $clog2(K + 1);
  localparam int NW = $clog2(ND + 1);
  localparam int PW = $clog2(SX + 1);
  localparam int SW = $clog2(NDATA + 1);

  localparam logic [CW-1:0] K_C      = CW'(K);
  localparam logic [PW-1:0] PH_LAST  = PW'(SX);
  localparam logic [PW-1:0] PH_XL    = PW'(SX - 1);
  localparam logic [SW-1:0] SMP_LAST = SW'(NDATA - 1);
  localparam logic [A-1:0]  T0_A     = A'(T0);
  localparam logic [ND-1:0] C_TOP    = ND'(1) << (ND - 1);
  localparam logic [K-1:0]  B_TOP    = K'(1) << (K - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, SAVE, FIN} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, wcnt;
  logic [NW-1:0] nidx;
  logic [PW-1:0] ph;
  logic [15:0]   smp, batch_r, max_r, iter;
  logic          mode_r;
  logic [A-1:0]  x_addr, y_addr, t_addr, nd_addr;
  logic [SW-1:0] xs, ts;

  logic          e_x, e_nd, in_we, dtb, nd_we, y_we;
  logic [ND-1:0] c_we;
  logic [K-1:0]  bp_we;
  logic          start_ok, xfire, commit, go, iter_again, seq_st;

  // Coefficient words per node: fan-in of the previous layer plus the bias.
  function automatic logic [CW-1:0] node_words(input logic [NW-1:0] j);
    int            acc;
    int            n;
    logic [CW-1:0] w;
    acc = 0;
    w   = '0;
    for (int l = 1; l < LTOT; l++) begin
      n = int'(LR[32*l +: 32]);
      if (int'(j) >= acc && int'(j) < acc + n)
        w = CW'(int'(LR[32*(l-1) +: 32]) + 1);
      acc += n;
    end
    return w;
  endfunction

  assign start_ok   = bus.start && (bus.batch != '0) && (!bus.mode || bus.max_it != '0);
  assign xfire      = (state == RUN) && (smp != batch_r) && (ph != PH_LAST);
  assign commit     = (state == RUN) && (ph == '0) && (smp != '0);
  assign go         = (state == IDLE) && (state_nx == LOAD);
  assign iter_again = (state == SAVE) && (state_nx == LOAD);
  assign seq_st     = (state == LOAD) || (state == SAVE);

  always_comb begin
    state_nx = state;
    e_x      = 1'b0;
    e_nd     = 1'b0;
    in_we    = 1'b0;
    c_we     = '0;
    bp_we    = '0;
    dtb      = 1'b0;
    nd_we    = 1'b0;
    y_we     = 1'b0;
    case (state)
      IDLE: if (start_ok) state_nx = LOAD;
      LOAD: begin
        e_nd = 1'b1;
        if (cnt != '0) c_we = C_TOP >> nidx;
        if (cnt == K_C) state_nx = RUN;
      end
      RUN: begin
        e_x   = xfire;
        in_we = (smp != batch_r) && (ph != '0);
        if (commit) begin
          if (mode_r) bp_we = '1;
          else        y_we  = 1'b1;
        end
        if (smp == batch_r) state_nx = mode_r ? SAVE : FIN;
      end
      SAVE: begin
        dtb = 1'b1;
        if (cnt != '0) begin
          nd_we = 1'b1;
          bp_we = B_TOP >> (cnt - 1'b1);
        end
        if (cnt == K_C) state_nx = (iter + 16'd1 < max_r) ? LOAD : FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.abort) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wcnt    <= '0;
      nidx    <= '0;
      ph      <= '0;
      smp     <= '0;
      mode_r  <= 1'b0;
      batch_r <= '0;
      max_r   <= '0;
      iter    <= '0;
      x_addr  <= '0;
      y_addr  <= '0;
      t_addr  <= T0_A;
      nd_addr <= '0;
      xs      <= '0;
      ts      <= '0;
    end else begin
      state <= state_nx;

      if (go) begin
        mode_r  <= bus.mode;
        batch_r <= bus.batch;
        max_r   <= bus.max_it;
        iter    <= '0;
      end else if (state == SAVE && cnt == K_C && !bus.abort) begin
        iter <= iter + 16'd1;
      end

      // LOAD/SAVE word counter and coefficient-memory address
      if (state_nx != state) cnt <= '0;
      else if (seq_st)       cnt <= cnt + 1'b1;

      if (state_nx != state && (state_nx == LOAD || state_nx == SAVE)) nd_addr <= '0;
      else if (seq_st && state_nx == state)                            nd_addr <= nd_addr + 1'b1;

      if (state != LOAD) begin
        nidx <= '0;
        wcnt <= '0;
      end else if (cnt != '0) begin
        if (wcnt + 1'b1 == node_words(nidx)) begin
          wcnt <= '0;
          nidx <= nidx + 1'b1;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end

      // RUN sample/phase counters
      if (state != RUN) begin
        ph  <= '0;
        smp <= '0;
      end else if (ph == PH_LAST) begin
        ph  <= '0;
        smp <= smp + 16'd1;
      end else begin
        ph <= ph + 1'b1;
      end

      if (go || iter_again) y_addr <= '0;
      else if (commit)      y_addr <= y_addr + 1'b1;

      if (go || (iter_again && !ADV)) begin
        x_addr <= '0;
        xs     <= '0;
        t_addr <= T0_A;
        ts     <= '0;
      end else begin
        if (xfire) begin
          if (ph == PH_XL) begin
            xs     <= (xs == SMP_LAST) ? '0 : xs + 1'b1;
            x_addr <= (ADV && xs == SMP_LAST) ? '0 : x_addr + 1'b1;
          end else begin
            x_addr <= x_addr + 1'b1;
          end
        end
        if (commit) begin
          ts     <= (ts == SMP_LAST) ? '0 : ts + 1'b1;
          t_addr <= (ADV && ts == SMP_LAST) ? T0_A : t_addr + 1'b1;
        end
      end
    end
  end

  assign bus.x_addr  = x_addr;
  assign bus.y_addr  = y_addr;
  assign bus.t_addr  = t_addr;
  assign bus.nd_addr = nd_addr;
  assign bus.e_x     = e_x;
  assign bus.e_nd    = e_nd;
  assign bus.in_we   = in_we;
  assign bus.c_we    = c_we;
  assign bus.bp_we   = bp_we;
  assign bus.dtb     = dtb;
  assign bus.nd_we   = nd_we;
  assign bus.y_we    = y_we;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == FIN);
  assign bus.iter    = iter;

endmodule
